bank_resp_merger: RTL and testbench
===================================

BANK_RESP_MERGER -- requirements
Module: bank_resp_merger

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of reconstructed global address.
REQ-002 SHALL have parameter NUM_MODULES, default 8, number of banks (power of 2).
REQ-003 SHALL have parameter LOCAL_ADDR_WIDTH, default 10, in-bank address width.
REQ-004 SHALL have parameter MOD_ID_BITS, default 3, equal to log2(NUM_MODULES).
REQ-005 SHALL have parameter DATA_WIDTH, default 32, response data width.
REQ-006 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port hash_sel, input, 3, bank-mapping mode used on the request side (0 identity, 1 bit-reverse, 2 rotate-left-1).
REQ-009 SHALL have port bank_valid, input, NUM_MODULES, per-bank response valid.
REQ-010 SHALL have port bank_ready, output, NUM_MODULES, per-bank response accept.
REQ-011 SHALL have port bank_local_addr, input, NUM_MODULES*LOCAL_ADDR_WIDTH, bank b in slice b.
REQ-012 SHALL have port bank_data, input, NUM_MODULES*DATA_WIDTH, bank b in slice b.
REQ-013 SHALL have port out_valid, output, 1, merged response valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accept.
REQ-015 SHALL have port out_gaddr, output, ADDR_WIDTH, reconstructed global address.
REQ-016 SHALL have port out_data, output, DATA_WIDTH, response data.
REQ-017 SHALL have port out_bank, output, MOD_ID_BITS, physical bank that sourced the response.

Function
REQ-018 SHALL transfer from bank b when bank_valid[b] and bank_ready[b] are high on the same edge; out transfer when out_valid and out_ready are high.
REQ-019 SHALL arbitrate round-robin: search starts at pointer p and wraps modulo NUM_MODULES; after a grant to b, p becomes (b+1) mod NUM_MODULES; with no grant, p is unchanged.
REQ-020 SHALL assert at most one bank_ready bit per cycle, only to the granted valid bank, and only when the output buffer holds fewer than 2 entries; bank_ready is combinational from bank_valid, p and the registered occupancy.
REQ-021 SHALL recover the original module field from physical bank b using hash_sel sampled at acceptance: 0 identity, 1 bit-reverse, 2 rotate-right-1, 3..7 identity.
REQ-022 SHALL form out_gaddr as zeros in bits above LOCAL_ADDR_WIDTH+MOD_ID_BITS-1, the recovered module field at bits [LOCAL_ADDR_WIDTH+MOD_ID_BITS-1:LOCAL_ADDR_WIDTH], and local address in the low bits.
REQ-023 SHALL buffer accepted responses in a 2-entry FIFO; out_* present the head entry; latency is 1 cycle from bank acceptance to out_valid when the buffer is empty.
REQ-024 SHALL hold out_gaddr, out_data and out_bank stable while out_valid=1 and out_ready=0.
REQ-025 SHALL support push and pop on the same edge with occupancy unchanged; when full, no bank is accepted, even if out_ready=1 in that cycle.
REQ-026 SHALL never drop, duplicate or reorder accepted responses.

Reset
REQ-027 SHALL, while rst=1, force FIFO empty, p=0, out_valid=0, bank_ready=0, and out_gaddr, out_data and out_bank to 0.
REQ-028 SHALL discard buffered entries on reset mid-operation; first acceptance after release scans from bank 0.

Configuration
REQ-029 SHALL, when macro BANK_RESP_MERGER_STATS_EN is defined, add output port resp_count (16 bits) counting bank acceptances, saturating at 0xFFFF and reset to 0.
REQ-030 SHALL, when BANK_RESP_MERGER_STATS_EN is undefined, omit resp_count and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: hash_sel=0, bank 6 valid, local 0x3FF, data 0xA5A5A5A5 -> next cycle out_valid=1, out_gaddr=0x00001BFF, out_bank=6.
REQ-032 SHALL cover: hash_sel=1 and hash_sel=2, bank 6, local 0x005 -> out_gaddr=0x00000C05 in both modes.
REQ-033 SHALL cover: all 8 bank_valid held high, out_ready=1 -> grants in order 0,1,...,7,0, one per cycle, no gaps.
REQ-034 SHALL cover: out_ready=0, banks 1,2,5 valid -> banks 1 and 2 accepted, then bank_ready=0; head (bank 1) held stable; out_ready=1 -> order 1,2,5.
REQ-035 SHALL cover: rst pulsed with 2 entries buffered -> out_valid=0 immediately; after release, all 8 valid -> bank 0 granted first.
REQ-036 SHALL cover, with BANK_RESP_MERGER_STATS_EN: 70000 acceptances -> resp_count=0xFFFF.

Source files
------------

// File: rtl/bank_resp_merger.sv
// Merges per-bank read responses into one stream via round-robin arbitration and a 2-entry FIFO.
// Optional acceptance counter output enabled by defining BANK_RESP_MERGER_STATS_EN.
module bank_resp_merger #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned NUM_MODULES      = 8,
  parameter int unsigned LOCAL_ADDR_WIDTH = 10,
  parameter int unsigned MOD_ID_BITS      = 3,
  parameter int unsigned DATA_WIDTH       = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2:0]                             hash_sel,
  input  logic [NUM_MODULES-1:0]                 bank_valid,
  output logic [NUM_MODULES-1:0]                 bank_ready,
  input  logic [NUM_MODULES*LOCAL_ADDR_WIDTH-1:0] bank_local_addr,
  input  logic [NUM_MODULES*DATA_WIDTH-1:0]       bank_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ADDR_WIDTH-1:0]                  out_gaddr,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [MOD_ID_BITS-1:0]                 out_bank
`ifdef BANK_RESP_MERGER_STATS_EN
  ,
  output logic [15:0]                            resp_count
`endif
);

  localparam int unsigned ModMsb = LOCAL_ADDR_WIDTH + MOD_ID_BITS - 1;

  logic [MOD_ID_BITS-1:0] ptr_q, ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  gaddr_q [2];
  logic [DATA_WIDTH-1:0]  data_q  [2];
  logic [MOD_ID_BITS-1:0] bank_q  [2];

  logic                   found;
  logic [MOD_ID_BITS-1:0] gnt_idx;
  logic [MOD_ID_BITS-1:0] idx;
  logic                   push;
  logic                   pop;
  logic [MOD_ID_BITS-1:0] mod_rev;
  logic [MOD_ID_BITS-1:0] mod_rot;
  logic [MOD_ID_BITS-1:0] mod_fld;
  logic [ADDR_WIDTH-1:0]  new_gaddr;
  logic [DATA_WIDTH-1:0]  new_data;

  // Round-robin search; index arithmetic wraps naturally since NUM_MODULES is a power of 2.
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr_q;
    idx     = ptr_q;
    for (int i = 0; i < NUM_MODULES; i++) begin
      idx = ptr_q + MOD_ID_BITS'(i);
      if (!found && bank_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign push = found && (cnt_q != 2'd2) && !rst;
  assign pop  = (cnt_q != 2'd0) && out_ready;

  always_comb begin
    bank_ready = '0;
    if (push) begin
      bank_ready[gnt_idx] = 1'b1;
    end
  end

  // Undo the request-side bank hash: rotate-left on requests is undone by rotate-right here.
  always_comb begin
    mod_rev = '0;
    mod_rot = '0;
    for (int i = 0; i < MOD_ID_BITS; i++) begin
      mod_rev[i] = gnt_idx[MOD_ID_BITS-1-i];
      mod_rot[i] = gnt_idx[(i+1) % MOD_ID_BITS];
    end
    case (hash_sel)
      3'd1:    mod_fld = mod_rev;
      3'd2:    mod_fld = mod_rot;
      default: mod_fld = gnt_idx;
    endcase
    new_gaddr = '0;
    new_gaddr[LOCAL_ADDR_WIDTH-1:0] =
        bank_local_addr[gnt_idx*LOCAL_ADDR_WIDTH +: LOCAL_ADDR_WIDTH];
    new_gaddr[ModMsb:LOCAL_ADDR_WIDTH] = mod_fld;
    new_data = bank_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    ptr_d = push ? gnt_idx + MOD_ID_BITS'(1) : ptr_q;
    rd_d  = rd_q ^ pop;
    wr_d  = wr_q ^ push;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        gaddr_q[i] <= '0;
        data_q[i]  <= '0;
        bank_q[i]  <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      if (push) begin
        gaddr_q[wr_q] <= new_gaddr;
        data_q[wr_q]  <= new_data;
        bank_q[wr_q]  <= gnt_idx;
      end
    end
  end

  // Outputs read as zero whenever the buffer is empty, including throughout reset.
  assign out_valid = (cnt_q != 2'd0);
  assign out_gaddr = out_valid ? gaddr_q[rd_q] : '0;
  assign out_data  = out_valid ? data_q[rd_q]  : '0;
  assign out_bank  = out_valid ? bank_q[rd_q]  : '0;

`ifdef BANK_RESP_MERGER_STATS_EN
  logic [15:0] resp_cnt_q, resp_cnt_d;

  assign resp_cnt_d = (push && resp_cnt_q != 16'hFFFF) ? resp_cnt_q + 16'd1 : resp_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_cnt_q <= '0;
    end else begin
      resp_cnt_q <= resp_cnt_d;
    end
  end

  assign resp_count = resp_cnt_q;
`endif

endmodule

// File: tb/tb_bank_resp_merger.sv
// Randomized and directed bench for bank_resp_merger against a queue-based reference model.
module tb_bank_resp_merger;
  localparam int NM = 8;
  localparam int LW = 10;
  localparam int MB = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       hash_sel = '0;
  logic [NM-1:0]    bank_valid = '0;
  logic [NM-1:0]    bank_ready;
  logic [NM*LW-1:0] bank_local_addr = '0;
  logic [NM*DW-1:0] bank_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW-1:0]    out_gaddr;
  logic [DW-1:0]    out_data;
  logic [MB-1:0]    out_bank;
`ifdef BANK_RESP_MERGER_STATS_EN
  logic [15:0]      resp_count;
`endif

  bank_resp_merger #(
    .ADDR_WIDTH      (AW),
    .NUM_MODULES     (NM),
    .LOCAL_ADDR_WIDTH(LW),
    .MOD_ID_BITS     (MB),
    .DATA_WIDTH      (DW)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .hash_sel       (hash_sel),
    .bank_valid     (bank_valid),
    .bank_ready     (bank_ready),
    .bank_local_addr(bank_local_addr),
    .bank_data      (bank_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_gaddr      (out_gaddr),
    .out_data       (out_data),
    .out_bank       (out_bank)
`ifdef BANK_RESP_MERGER_STATS_EN
    ,
    .resp_count     (resp_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] gaddr;
    logic [DW-1:0] data;
    int            bank;
  } resp_t;

  resp_t         mdl_q[$];
  int            mdl_p = 0;
  int            mdl_cnt = 0;
  int            n_total = 0;
  int            n_bad = 0;
  logic [NM-1:0] seen_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int recover(input int b, input int hs);
    int r;
    r = b;
    if (hs == 1) begin
      r = 0;
      for (int k = 0; k < MB; k++) if (((b >> k) & 1) != 0) r = r | (1 << (MB - 1 - k));
    end else if (hs == 2) begin
      r = (b >> 1) | ((b & 1) << (MB - 1));
    end
    return r;
  endfunction

  function automatic int pick();
    if (rst || mdl_q.size() >= 2) return -1;
    for (int i = 0; i < NM; i++) begin
      int b;
      b = (mdl_p + i) % NM;
      if (bank_valid[b]) return b;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input bit hold);
    int    g;
    resp_t r;
    bit    popped;
    #1;
    g = pick();
    seen_ready = bank_ready;
    check_eq("bank_ready", bank_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check_eq("out_valid", out_valid, (mdl_q.size() > 0) ? 64'd1 : 64'd0);
    if (mdl_q.size() > 0) begin
      check_eq("out_gaddr", out_gaddr, mdl_q[0].gaddr);
      check_eq("out_data", out_data, mdl_q[0].data);
      check_eq("out_bank", out_bank, mdl_q[0].bank);
    end
`ifdef BANK_RESP_MERGER_STATS_EN
    check_eq("resp_count", resp_count, mdl_cnt);
`endif
    r.bank  = g;
    r.gaddr = '0;
    r.data  = '0;
    if (g >= 0) begin
      r.gaddr = AW'(recover(g, int'(hash_sel)) * (1 << LW) + int'(bank_local_addr[g*LW +: LW]));
      r.data  = bank_data[g*DW +: DW];
    end
    popped = (mdl_q.size() > 0) && out_ready;
    @(posedge clk);
    if (popped) void'(mdl_q.pop_front());
    if (g >= 0) begin
      mdl_q.push_back(r);
      mdl_p = (g + 1) % NM;
      if (mdl_cnt < 65535) mdl_cnt++;
    end
    @(negedge clk);
    if (!hold && g >= 0) bank_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst bank_ready", bank_ready, 0);
    check_eq("rst out_gaddr", out_gaddr, 0);
    check_eq("rst out_data", out_data, 0);
    check_eq("rst out_bank", out_bank, 0);
    repeat (2) @(negedge clk);
    mdl_q.delete();
    mdl_p   = 0;
    mdl_cnt = 0;
    rst     = 1'b0;
  endtask

  task automatic load(input int b, input logic [LW-1:0] la, input logic [DW-1:0] d);
    bank_local_addr[b*LW +: LW] = la;
    bank_data[b*DW +: DW]       = d;
    bank_valid[b]               = 1'b1;
  endtask

  initial begin
    int exp_order[3];
    @(negedge clk);
    do_reset();

    // Round-robin with every bank continuously valid
    bank_valid = '1;
    out_ready  = 1'b1;
    for (int i = 0; i < NM + 1; i++) begin
      step(1'b1);
      check_eq("rr order", seen_ready, 64'd1 << (i % NM));
    end
    bank_valid = '0;
    repeat (2) step(1'b0);

    // Identity mapping, bank 6
    do_reset();
    hash_sel  = 3'd0;
    out_ready = 1'b0;
    load(6, 10'h3FF, 32'hA5A5A5A5);
    step(1'b0);
    check_eq("id valid", out_valid, 1);
    check_eq("id gaddr", out_gaddr, 32'h0000_1BFF);
    check_eq("id bank", out_bank, 6);
    check_eq("id data", out_data, 32'hA5A5A5A5);
    out_ready = 1'b1;
    step(1'b0);

    // Bit-reverse and rotate modes; hash_sel changed after acceptance must not matter
    for (int hs = 1; hs <= 2; hs++) begin
      hash_sel  = 3'(hs);
      out_ready = 1'b0;
      load(6, 10'h005, $urandom);
      step(1'b0);
      hash_sel = 3'd0;
      check_eq("hash gaddr", out_gaddr, 32'h0000_0C05);
      out_ready = 1'b1;
      step(1'b0);
    end

    // Backpressure: banks 1,2 fill the buffer, 5 waits; full blocks even when out_ready=1
    do_reset();
    out_ready = 1'b0;
    load(1, $urandom, $urandom);
    load(2, $urandom, $urandom);
    load(5, $urandom, $urandom);
    step(1'b0);
    check_eq("bp grant1", seen_ready, 8'b0000_0010);
    step(1'b0);
    check_eq("bp grant2", seen_ready, 8'b0000_0100);
    step(1'b0);
    check_eq("bp full ready", seen_ready, 0);
    check_eq("bp head", out_bank, 1);
    step(1'b0);
    check_eq("bp head hold", out_bank, 1);
    out_ready    = 1'b1;
    exp_order[0] = 1;
    exp_order[1] = 2;
    exp_order[2] = 5;
    for (int k = 0; k < 3; k++) begin
      check_eq("bp order", out_bank, exp_order[k]);
      step(1'b0);
      if (k == 0) check_eq("full no accept", seen_ready, 0);
    end
    step(1'b0);

    // Reset with two buffered entries, then scan restarts at bank 0
    out_ready = 1'b0;
    load(3, $urandom, $urandom);
    load(4, $urandom, $urandom);
    step(1'b0);
    step(1'b0);
    check_eq("pre-rst valid", out_valid, 1);
    do_reset();
    bank_valid = '1;
    step(1'b0);
    check_eq("post-rst grant", seen_ready, 8'b0000_0001);
    bank_valid = '0;
    out_ready  = 1'b1;
    repeat (2) step(1'b0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bank_valid = NM'($urandom);
      hash_sel   = 3'($urandom);
      out_ready  = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      for (int b = 0; b < NM; b++) begin
        bank_local_addr[b*LW +: LW] = LW'($urandom);
        bank_data[b*DW +: DW]       = $urandom;
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1'b1);
    end

`ifdef BANK_RESP_MERGER_STATS_EN
    do_reset();
    bank_valid = '1;
    out_ready  = 1'b1;
    repeat (70000) step(1'b1);
    check_eq("resp_count sat", resp_count, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
